// File: rtl/display_pkg.sv
// display_pkg
// Shared types and constants for the multiplexed 7-segment scan controller:
//   seg_t        - active-low segment vector {a,b,c,d,e,f,g}, bit6 = a
//   SEG_BLANK    - all segments off
//   SEG_TABLE    - hex nibble to active-low segment code
//   scan_state_t - per-slot phase: GUARD (all anodes off) then SHOW
package display_pkg;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_BLANK = 7'b1111111;

  localparam seg_t SEG_TABLE [0:15] = '{
    7'b0000001,  // 0
    7'b1001111,  // 1
    7'b0010010,  // 2
    7'b0000110,  // 3
    7'b1001100,  // 4
    7'b0100100,  // 5
    7'b0100000,  // 6
    7'b0001111,  // 7
    7'b0000000,  // 8
    7'b0000100,  // 9
    7'b0001000,  // A
    7'b1100000,  // b
    7'b0110001,  // C
    7'b1000010,  // d
    7'b0110000,  // E
    7'b0111000   // F
  };

  typedef enum logic {
    GUARD = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

endpackage

// File: rtl/display_scan_seg_decode.sv
// seg_decode
// Combinational hex nibble to active-low 7-segment code.
// Ports:
//   nibble - 4-bit hex digit
//   seg    - active-low segments {a..g}; an unknown nibble falls to the
//            default arm and decodes to blank
module seg_decode
  import display_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);

  // Table lookup; the default arm also catches X/Z nibbles in simulation.
  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0:    seg = SEG_TABLE[0];
      4'h1:    seg = SEG_TABLE[1];
      4'h2:    seg = SEG_TABLE[2];
      4'h3:    seg = SEG_TABLE[3];
      4'h4:    seg = SEG_TABLE[4];
      4'h5:    seg = SEG_TABLE[5];
      4'h6:    seg = SEG_TABLE[6];
      4'h7:    seg = SEG_TABLE[7];
      4'h8:    seg = SEG_TABLE[8];
      4'h9:    seg = SEG_TABLE[9];
      4'hA:    seg = SEG_TABLE[10];
      4'hB:    seg = SEG_TABLE[11];
      4'hC:    seg = SEG_TABLE[12];
      4'hD:    seg = SEG_TABLE[13];
      4'hE:    seg = SEG_TABLE[14];
      4'hF:    seg = SEG_TABLE[15];
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
// Time-multiplexes one hex decoder across NUM_DIGITS common-anode digits on a
// shared segment bus. A load strobe captures value/digit_en into a shadow
// buffer; the shadow is promoted to the active buffer only when the digit
// index wraps, so a frame never mixes old and new digits. Each slot starts
// with GUARD_CYCLES of all-anodes-off to suppress ghosting.
// Optional: define DISPLAY_SCAN_LZB_EN for leading-zero blanking.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   value       - packed nibbles, digit 0 in bits [3:0]
//   load        - one-cycle capture strobe for value and digit_en
//   digit_en    - per-digit enable (disabled digit keeps its anode off)
//   seg         - registered active-low segments {a..g}
//   an          - registered active-low anode select
//   frame_tick  - one-cycle pulse when the active buffer is updated
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int SLOT_CYCLES  = 50000,
  parameter int GUARD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    load,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0]      GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
  localparam logic [CNT_W-1:0]      SLOT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{1'b1}};

  scan_state_t               state_r, state_s;
  logic [CNT_W-1:0]          cnt_r, cnt_s;
  logic [IDX_W-1:0]          idx_r, idx_s;
  logic                      wrap_s;
  logic [4*NUM_DIGITS-1:0]   shadow_val_r, active_val_r;
  logic [NUM_DIGITS-1:0]     shadow_en_r, active_en_r;
  logic                      pending_r;
  logic [3:0]                nib_s;
  seg_t                      dec_seg_s, seg_s;
  logic [NUM_DIGITS-1:0]     an_s;
  logic                      lz_blank_s;

  // Scan state, slot counter and digit index registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= GUARD;
      cnt_r   <= CNT_W'(0);
      idx_r   <= IDX_W'(0);
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
    end
  end

  // Next-state logic; the slot counter spans guard and show phases.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r + CNT_W'(1);
    idx_s   = idx_r;
    wrap_s  = 1'b0;
    case (state_r)
      GUARD: begin
        if (cnt_r == GUARD_LAST) state_s = SHOW;
        else                     state_s = GUARD;
      end
      SHOW: begin
        if (cnt_r == SLOT_LAST) begin
          state_s = GUARD;
          cnt_s   = CNT_W'(0);
          if (idx_r == IDX_LAST) begin
            idx_s  = IDX_W'(0);
            wrap_s = 1'b1;
          end else begin
            idx_s  = idx_r + IDX_W'(1);
          end
        end else begin
          state_s = SHOW;
        end
      end
      default: begin
        state_s = GUARD;
        cnt_s   = CNT_W'(0);
        idx_s   = IDX_W'(0);
      end
    endcase
  end

  // Double buffer: a load coinciding with the wrap bypasses the shadow so
  // the freshly loaded value is the one promoted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_val_r <= '0;
      shadow_en_r  <= '0;
      active_val_r <= '0;
      active_en_r  <= '0;
      pending_r    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val_r <= value;
        shadow_en_r  <= digit_en;
      end
      if (wrap_s && load) begin
        active_val_r <= value;
        active_en_r  <= digit_en;
        pending_r    <= 1'b0;
      end else if (wrap_s && pending_r) begin
        active_val_r <= shadow_val_r;
        active_en_r  <= shadow_en_r;
        pending_r    <= 1'b0;
      end else if (load) begin
        pending_r    <= 1'b1;
      end
    end
  end

  assign nib_s = active_val_r[{idx_r, 2'b00} +: 4];

  seg_decode u_seg_decode (
    .nibble (nib_s),
    .seg    (dec_seg_s)
  );

`ifdef DISPLAY_SCAN_LZB_EN
  logic higher_nz_s;

  // Blank a zero digit when every enabled higher digit is also zero;
  // digit 0 is exempt so an all-zero value still shows one "0".
  always_comb begin
    higher_nz_s = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      higher_nz_s = higher_nz_s |
                    ((j > int'(idx_r)) && active_en_r[j] &&
                     (active_val_r[4*j +: 4] != 4'h0));
    end
    lz_blank_s = (nib_s == 4'h0) && (idx_r != IDX_W'(0)) && !higher_nz_s;
  end
`else
  assign lz_blank_s = 1'b0;
`endif

  // Pin values for the current phase; registered below.
  always_comb begin
    an_s  = AN_OFF;
    seg_s = SEG_BLANK;
    if ((state_r == SHOW) && active_en_r[idx_r]) begin
      an_s[idx_r] = 1'b0;
      if (lz_blank_s) seg_s = SEG_BLANK;
      else            seg_s = dec_seg_s;
    end else begin
      an_s  = AN_OFF;
      seg_s = SEG_BLANK;
    end
  end

  // Output registers: seg and an update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      an         <= AN_OFF;
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_s;
      an         <= an_s;
      frame_tick <= wrap_s && (pending_r || load);
    end
  end

endmodule

// File: doc/display_scan_ctrl.md
Name: display_scan_ctrl

Overview:
- Time-multiplexes one hex-to-7-segment decoder across NUM_DIGITS common-anode digits that share one segment bus.
- Latches a packed hex value through a double buffer and scans digits round-robin.
- Inserts a blanking guard between digits to suppress ghosting.
- Sits between the datapath producing hex nibbles and the board's segment/anode pins.

Parameters:
- NUM_DIGITS, 4, digits scanned; legal range 2..8.
- SLOT_CYCLES, 50000, clock cycles per digit slot, guard included; must be greater than GUARD_CYCLES.
- GUARD_CYCLES, 500, cycles at the start of each slot with all anodes off.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- value  input  4*NUM_DIGITS  packed nibbles; digit 0 = bits [3:0].
- load  input  1  one-cycle strobe; captures value and digit_en into the shadow buffer.
- digit_en  input  NUM_DIGITS  per-digit enable; a disabled digit keeps its anode off for its whole slot.
- seg  output  7  active-low segments {a,b,c,d,e,f,g}; bit6 = a, bit0 = g.
- an  output  NUM_DIGITS  active-low anode select.
- frame_tick  output  1  one-cycle pulse when the active buffer is updated at a frame start.

Behaviour:
- Reset: the following take these values immediately on reset assertion (asynchronous).
  - seg = 7'b1111111, an = all ones.
  - Active and shadow buffers = 0; enables = all zeros.
  - pending = 0, slot counter = 0, digit index = 0, state = GUARD, frame_tick = 0.
- Shadow buffer:
  - load=1 captures value and digit_en into the shadow buffer and sets pending.
  - A second load before the frame boundary overwrites the shadow buffer; the last load wins.
- Frame boundary: the cycle the digit index wraps from NUM_DIGITS-1 to 0.
  - If pending, the shadow buffer copies to the active buffer, pending clears, and frame_tick pulses in the same cycle.
  - If load and the boundary coincide, the newly loaded value is the one copied.
  - The display never shows a mix of old and new digits within a frame (no tearing).
- State machine:
  - GUARD: an = all ones, seg = 7'b1111111.
    - Slot counter counts 0..GUARD_CYCLES-1, then moves to SHOW.
  - SHOW: an[idx] = 0 if active_en[idx], else all ones.
    - seg = decode(active nibble idx); all ones if the digit is disabled.
    - At slot counter = SLOT_CYCLES-1: counter resets to 0, idx increments modulo NUM_DIGITS, state returns to GUARD.
- Registered outputs:
  - seg and an are registered: one cycle of latency from state/idx change to the pins.
  - seg and an change in the same cycle, so no single-cycle glitch drives the wrong digit.
- Decoder codes, active-low {a..g}:
  - 0 = 0000001, 1 = 1001111, 2 = 0010010, 3 = 0000110
  - 4 = 1001100, 5 = 0100100, 6 = 0100000, 7 = 0001111
  - 8 = 0000000, 9 = 0000100, A = 0001000, b = 1100000
  - C = 0110001, d = 1000010, E = 0110000, F = 0111000
  - Any X/undefined input decodes to 1111111.
- Counter width: $clog2(SLOT_CYCLES); idx width: $clog2(NUM_DIGITS).
- Reset mid-slot: outputs blank immediately; the scan restarts at digit 0 in GUARD.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN.
- Defined: leading-zero blanking.
  - While in SHOW, a digit whose nibble is 0 and all of whose higher-index digits are 0 (within active_en) is shown blank: seg all ones, anode still driven.
  - Digit 0 is never blanked, so value 0 shows a single "0".
- Undefined: every enabled digit shows its decoded nibble, zeros included.

Decomposition:
- Package display_pkg holds:
  - SEG_BLANK = 7'b1111111;
  - the 16-entry segment constant table;
  - typedef seg_t (logic [6:0]);
  - the scan state enum {GUARD, SHOW}.
- Sub-module seg_decode (combinational nibble to seg_t using the package table) is instantiated once.

Test Plan:
- Reset/scan: rst_n low, then high.
  - seg = 1111111 and an = 1111 during reset.
  - After load of value=16'h1234 with digit_en=4'hF, the following frame shows an=1110/seg=1001100 (4), an=1101/seg=0000110 (3), etc.
  - Each SHOW phase lasts SLOT_CYCLES-GUARD_CYCLES cycles.
- Tear-free load:
  - load 16'hABCD mid-frame leaves the current frame unchanged.
  - frame_tick pulses once at the wrap; the next frame shows D,C,b,A.
- Coincident load and wrap: load 16'h00FF on the wrap cycle -> that frame displays FF00 digits immediately and frame_tick = 1.
- Disabled digit: digit_en = 4'b1011 -> digit 2's slot keeps an = 1111 and seg = 1111111 for the full slot; the scan timing is unchanged.
- Guard: at every slot boundary, an = all ones for exactly GUARD_CYCLES cycles, with no overlap of two active anodes.
- DISPLAY_SCAN_LZB_EN: value = 16'h0050.
  - Digits 3 and 2 are blank with anodes driven; digit 1 shows 0100100 and digit 0 shows 0000001.
  - value 16'h0000 shows digit 0 only.
